// File: rtl/patch_pkg.sv
// Shared types and width helpers for the LK patch window generator.
// Dimension helper derives per-level image size from the level-0 size.
package patch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int DEF_PR     = 16;
  localparam int DEF_PC     = 16;
  localparam int DEF_ROWS   = 436;
  localparam int DEF_COLS   = 1024;
  localparam int DEF_LEVELS = 3;

  // Index width for a range of n values; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a patch-relative index for a patch of 2*half+1 positions.
  function automatic int patch_w(input int half);
    return idx_w(2 * half + 1);
  endfunction

  localparam int DEF_ROW_W  = idx_w(DEF_ROWS);
  localparam int DEF_COL_W  = idx_w(DEF_COLS);
  localparam int DEF_PROW_W = patch_w(DEF_PR);
  localparam int DEF_PCOL_W = patch_w(DEF_PC);

  // Size of one axis on pyramid level lv.
  function automatic int unsigned lvl_dim(input int unsigned full, input int unsigned lv);
    return full >> lv;
  endfunction

endpackage

// File: rtl/coord_clamp.sv
// Bounds check of one signed tap coordinate against an axis size: returns the
// coordinate pulled into 0..limit-1 and whether it was outside. Purely combinational.
module coord_clamp #(
  parameter int CW = 11,
  parameter int LW = 10
) (
  input  logic signed [CW-1:0] coord,
  input  logic        [LW-1:0] limit,
  output logic        [LW-1:0] clamped,
  output logic                 oob
);

  logic signed [CW-1:0] lim_s;

  assign lim_s = $signed({{(CW-LW){1'b0}}, limit});

  always_comb begin
    clamped = coord[LW-1:0];
    oob     = 1'b0;
    if (coord[CW-1]) begin
      clamped = '0;
      oob     = 1'b1;
    end else if (coord >= lim_s) begin
      clamped = limit - 1'b1;
      oob     = 1'b1;
    end
  end

endmodule

// File: rtl/patch_window_gen.sv
// 2x2 bilinear tap addresses for every position of a tracking patch, one window per cycle;
// first window 2 cycles after start, outputs frozen while out_ready is low. PATCH_CLAMP_EN selects border replication.
module patch_window_gen
  import patch_pkg::*;
#(
  parameter int PR     = 16,
  parameter int PC     = 16,
  parameter int ROWS   = 436,
  parameter int COLS   = 1024,
  parameter int LEVELS = 3,
  parameter int IMBITS = 20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [idx_w(ROWS)-1:0]    ctr_row,
  input  logic [idx_w(COLS)-1:0]    ctr_col,
  input  logic [idx_w(LEVELS)-1:0]  level,
  input  logic [IMBITS-1:0]         lvl_base,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IMBITS-1:0]         addr_tl,
  output logic [IMBITS-1:0]         addr_tr,
  output logic [IMBITS-1:0]         addr_bl,
  output logic [IMBITS-1:0]         addr_br,
  output logic [patch_w(PR)-1:0]    out_prow,
  output logic [patch_w(PC)-1:0]    out_pcol,
  output logic                      out_oob,
  output logic                      row_done,
  output logic                      patch_done
);

  localparam int RW  = idx_w(ROWS);
  localparam int CW  = idx_w(COLS);
  localparam int LVW = idx_w(LEVELS);
  localparam int PRW = patch_w(PR);
  localparam int PCW = patch_w(PC);
  localparam int RTW = RW + 2;
  localparam int CTW = CW + 2;
  localparam int AW  = IMBITS + 2;

  localparam logic [PRW-1:0] PROW_LAST = PRW'(2 * PR);
  localparam logic [PCW-1:0] PCOL_LAST = PCW'(2 * PC);
  localparam logic signed [RTW-1:0] R_ONE = RTW'(1);
  localparam logic signed [RTW-1:0] R_TWO = RTW'(2);
  localparam logic signed [CTW-1:0] C_ONE = CTW'(1);

  state_t state_q, state_nxt;

  logic [RW-1:0]     ctr_row_q;
  logic [CW-1:0]     ctr_col_q;
  logic [LVW-1:0]    level_q;
  logic [IMBITS-1:0] base_q;

  logic signed [RTW-1:0] cur_r, row_in, row_in1, row_p2, r0_x;
  logic signed [CTW-1:0] cur_c, col_in1, c0_x;
  logic signed [RW:0]    r0;
  logic signed [CW:0]    c0;
  logic [PRW-1:0]        prow_q;
  logic [PCW-1:0]        pcol_q;

  // rb_top / rb_bot hold the row bases of the (clamped) top and bottom tap rows.
  logic signed [AW-1:0] rb_top, rb_bot, base_x, w_x, rb_setup;
  logic [AW-1:0]        prod;
  logic [IMBITS-1:0]    a_tl, a_tr, a_bl, a_br;

  logic [RW:0] h_dim, rt_cl, rb_cl;
  logic [CW:0] w_dim, ct_cl, cr_cl;
  logic        rt_oob, rb_oob, ct_oob, cr_oob;
  logic        run, hs, last_col, last_row, run_step;

  assign h_dim = (RW+1)'(lvl_dim(ROWS, 32'(level_q)));
  assign w_dim = (CW+1)'(lvl_dim(COLS, 32'(level_q)));

  assign r0   = $signed({1'b0, ctr_row_q}) - $signed((RW+1)'(PR));
  assign c0   = $signed({1'b0, ctr_col_q}) - $signed((CW+1)'(PC));
  assign r0_x = RTW'(r0);
  assign c0_x = CTW'(c0);

  assign run      = (state_q == RUN);
  assign hs       = run & out_ready;
  assign last_col = (pcol_q == PCOL_LAST);
  assign last_row = (prow_q == PROW_LAST);
  assign busy     = (state_q != IDLE);

  // During SETUP the row checkers look at r0 so the one multiply uses its clamped row.
  assign row_in  = (state_q == SETUP) ? r0_x : cur_r;
  assign row_in1 = row_in + R_ONE;
  assign col_in1 = cur_c + C_ONE;
  assign row_p2  = cur_r + R_TWO;

  coord_clamp #(.CW(RTW), .LW(RW+1)) u_row_top (
    .coord(row_in), .limit(h_dim), .clamped(rt_cl), .oob(rt_oob)
  );
  coord_clamp #(.CW(RTW), .LW(RW+1)) u_row_bot (
    .coord(row_in1), .limit(h_dim), .clamped(rb_cl), .oob(rb_oob)
  );
  coord_clamp #(.CW(CTW), .LW(CW+1)) u_col_left (
    .coord(cur_c), .limit(w_dim), .clamped(ct_cl), .oob(ct_oob)
  );
  coord_clamp #(.CW(CTW), .LW(CW+1)) u_col_right (
    .coord(col_in1), .limit(w_dim), .clamped(cr_cl), .oob(cr_oob)
  );

  assign base_x   = $signed({2'b00, base_q});
  assign w_x      = $signed(AW'(w_dim));
  assign prod     = AW'(rt_cl) * AW'(w_dim);
  assign rb_setup = base_x + $signed(prod);

  // Next bottom row differs from the current one only while r+2 stays inside 1..H-1.
  assign run_step = !row_p2[RTW-1] && (row_p2 != '0) && (row_p2 < $signed({1'b0, h_dim}));

  assign a_tl = IMBITS'(rb_top + $signed(AW'(ct_cl)));
  assign a_tr = IMBITS'(rb_top + $signed(AW'(cr_cl)));
  assign a_bl = IMBITS'(rb_bot + $signed(AW'(ct_cl)));
  assign a_br = IMBITS'(rb_bot + $signed(AW'(cr_cl)));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = RUN;
      RUN:     if (hs && last_col && last_row) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_row_q <= '0;
      ctr_col_q <= '0;
      level_q   <= '0;
      base_q    <= '0;
      cur_r     <= '0;
      cur_c     <= '0;
      prow_q    <= '0;
      pcol_q    <= '0;
      rb_top    <= '0;
      rb_bot    <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        ctr_row_q <= ctr_row;
        ctr_col_q <= ctr_col;
        level_q   <= level;
        base_q    <= lvl_base;
      end
      if (state_q == SETUP) begin
        cur_r  <= r0_x;
        cur_c  <= c0_x;
        prow_q <= '0;
        pcol_q <= '0;
        rb_top <= rb_setup;
        rb_bot <= rb_setup + ((rb_cl != rt_cl) ? w_x : '0);
      end else if (hs) begin
        if (last_col) begin
          pcol_q <= '0;
          cur_c  <= c0_x;
          prow_q <= prow_q + 1'b1;
          cur_r  <= cur_r + R_ONE;
          rb_top <= rb_bot;
          rb_bot <= rb_bot + (run_step ? w_x : '0);
        end else begin
          pcol_q <= pcol_q + 1'b1;
          cur_c  <= col_in1;
        end
      end
    end
  end

  always_comb begin
    out_valid  = run;
    addr_tl    = '0;
    addr_tr    = '0;
    addr_bl    = '0;
    addr_br    = '0;
    out_prow   = '0;
    out_pcol   = '0;
    out_oob    = 1'b0;
    row_done   = 1'b0;
    patch_done = 1'b0;
    if (run) begin
`ifdef PATCH_CLAMP_EN
      addr_tl = a_tl;
      addr_tr = a_tr;
      addr_bl = a_bl;
      addr_br = a_br;
`else
      addr_tl = (rt_oob | ct_oob) ? base_q : a_tl;
      addr_tr = (rt_oob | cr_oob) ? base_q : a_tr;
      addr_bl = (rb_oob | ct_oob) ? base_q : a_bl;
      addr_br = (rb_oob | cr_oob) ? base_q : a_br;
`endif
      out_prow   = prow_q;
      out_pcol   = pcol_q;
      out_oob    = rt_oob | rb_oob | ct_oob | cr_oob;
      row_done   = hs & last_col;
      patch_done = hs & last_col & last_row;
    end
  end

endmodule

// File: tb/tb_patch_window_gen.sv
// Directed bench for patch_window_gen: every window is compared against a reference
// address model; handshake counts, timing and stall stability are checked per patch.
module tb_patch_window_gen;

  localparam int NWIN  = 1089;
  localparam int NCOLS = 33;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [8:0]  ctr_row;
  logic [9:0]  ctr_col;
  logic [1:0]  level;
  logic [19:0] lvl_base;
  logic        busy, out_valid, out_oob, row_done, patch_done;
  logic [19:0] addr_tl, addr_tr, addr_bl, addr_br;
  logic [5:0]  out_prow, out_pcol;

  int checks   = 0;
  int failures = 0;

  int res_hs, res_rd, res_pdn, res_pdcyc, res_fvcyc, res_endcyc, res_serr, res_stall;
  logic [19:0] res_ftl, res_fbl, res_ltl, res_mtl;
  logic        res_foob, res_moob;

  patch_window_gen dut (
    .clk(clk), .reset(reset), .start(start),
    .ctr_row(ctr_row), .ctr_col(ctr_col), .level(level), .lvl_base(lvl_base),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .addr_tl(addr_tl), .addr_tr(addr_tr), .addr_bl(addr_bl), .addr_br(addr_br),
    .out_prow(out_prow), .out_pcol(out_pcol), .out_oob(out_oob),
    .row_done(row_done), .patch_done(patch_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] model_addr(input logic [19:0] base, input int h, input int w,
                                             input int r, input int c);
    int cr, cc;
`ifdef PATCH_CLAMP_EN
    cr = (r < 0) ? 0 : ((r >= h) ? h - 1 : r);
    cc = (c < 0) ? 0 : ((c >= w) ? w - 1 : c);
    return base + 20'(cr * w + cc);
`else
    cr = r;
    cc = c;
    if (cr < 0 || cr >= h || cc < 0 || cc >= w) return base;
    return base + 20'(cr * w + cc);
`endif
  endfunction

  function automatic logic model_oob(input int h, input int w, input int r, input int c);
    return (r < 0) || (r + 1 >= h) || (c < 0) || (c + 1 >= w);
  endfunction

  // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: stray start mid-patch.
  task automatic run_patch(input int rc, input int cc, input int lv, input logic [19:0] base,
                           input int mode, input int abort_at);
    int h, w, r0, c0, pr, pcv, r, c;
    logic [93:0] snap;
    logic        snap_vld;
    logic [3:0]  pat;
    pat = 4'b1001;
    h = 436 >> lv;
    w = 1024 >> lv;
    r0 = rc - 16;
    c0 = cc - 16;
    res_hs = 0; res_rd = 0; res_pdn = 0; res_pdcyc = -1; res_fvcyc = -1;
    res_endcyc = -1; res_serr = 0; res_stall = 0;
    res_ftl = 'x; res_fbl = 'x; res_ltl = 'x; res_mtl = 'x; res_foob = 'x; res_moob = 'x;
    snap = '0;
    snap_vld = 1'b0;
    start = 1'b1; ctr_row = 9'(rc); ctr_col = 10'(cc); level = 2'(lv); lvl_base = base;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("setup_busy", busy, 1);
    check("setup_valid", out_valid, 0);
    for (int cyc = 2; cyc < 5000; cyc++) begin
      @(posedge clk); #1;
      res_endcyc = cyc;
      if (abort_at >= 0 && res_hs == abort_at) begin
        reset = 1'b1;
        break;
      end
      if (!busy) break;
      out_ready = (mode == 1) ? pat[cyc % 4] : 1'b1;
      start = (mode == 2 && cyc == 300);
      if (mode == 2 && cyc == 300) ctr_row = 9'd5;
      #1;
      if (out_valid && res_fvcyc < 0) res_fvcyc = cyc;
      if (snap_vld && ({out_valid, addr_tl, addr_tr, addr_bl, addr_br, out_prow, out_pcol, out_oob} !== snap))
        res_stall++;
      snap_vld = 1'b0;
      if (!out_valid && (row_done || patch_done)) res_serr++;
      if (out_valid && !out_ready) begin
        snap = {out_valid, addr_tl, addr_tr, addr_bl, addr_br, out_prow, out_pcol, out_oob};
        snap_vld = 1'b1;
        if (row_done || patch_done) res_serr++;
      end
      if (out_valid && out_ready) begin
        pr = res_hs / NCOLS;
        pcv = res_hs % NCOLS;
        r = r0 + pr;
        c = c0 + pcv;
        if (addr_tl !== model_addr(base, h, w, r, c)) res_serr++;
        if (addr_tr !== model_addr(base, h, w, r, c + 1)) res_serr++;
        if (addr_bl !== model_addr(base, h, w, r + 1, c)) res_serr++;
        if (addr_br !== model_addr(base, h, w, r + 1, c + 1)) res_serr++;
        if (out_oob !== model_oob(h, w, r, c)) res_serr++;
        if (out_prow !== 6'(pr) || out_pcol !== 6'(pcv)) res_serr++;
        if (row_done !== (pcv == NCOLS - 1)) res_serr++;
        if (patch_done !== (res_hs == NWIN - 1)) res_serr++;
        if (res_hs == 0) begin
          res_ftl = addr_tl; res_fbl = addr_bl; res_foob = out_oob;
        end
        if (res_hs == 16 * NCOLS + 16) begin
          res_mtl = addr_tl; res_moob = out_oob;
        end
        res_ltl = addr_tl;
        if (row_done) res_rd++;
        if (patch_done) begin
          res_pdn++;
          res_pdcyc = cyc;
        end
        res_hs++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    ctr_row = '0; ctr_col = '0; level = '0; lvl_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_oob", out_oob, 0);
    check("rst_row_done", row_done, 0);
    check("rst_patch_done", patch_done, 0);
    check("rst_addrs", {addr_tl, addr_tr, addr_bl, addr_br}, 0);
    check("rst_pos", {out_prow, out_pcol}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_patch(117, 195, 0, 20'd0, 0, -1);
    check("l0_first_valid_cycle", res_fvcyc, 2);
    check("l0_first_tl", res_ftl, 103603);
    check("l0_first_bl", res_fbl, 104627);
    check("l0_last_tl", res_ltl, 136403);
    check("l0_handshakes", res_hs, NWIN);
    check("l0_row_done", res_rd, 33);
    check("l0_patch_done_n", res_pdn, 1);
    check("l0_patch_done_cycle", res_pdcyc, 1090);
    check("l0_busy_fall_cycle", res_endcyc, 1091);
    check("l0_window_seq", res_serr, 0);

    run_patch(117, 195, 0, 20'd0, 1, -1);
    check("bp_first_valid_cycle", res_fvcyc, 2);
    check("bp_handshakes", res_hs, NWIN);
    check("bp_row_done", res_rd, 33);
    check("bp_patch_done_n", res_pdn, 1);
    check("bp_last_tl", res_ltl, 136403);
    check("bp_window_seq", res_serr, 0);
    check("bp_stall_stable", res_stall, 0);

    run_patch(50, 60, 1, 20'd446464, 0, -1);
    check("l1_first_tl", res_ftl, 463916);
    check("l1_first_bl", res_fbl, 464428);
    check("l1_handshakes", res_hs, NWIN);
    check("l1_window_seq", res_serr, 0);

    run_patch(0, 0, 0, 20'd5000, 0, -1);
    check("corner_first_tl", res_ftl, 5000);
    check("corner_first_oob", res_foob, 1);
    check("corner_mid_tl", res_mtl, 5000);
    check("corner_mid_oob", res_moob, 0);
    check("corner_handshakes", res_hs, NWIN);
    check("corner_window_seq", res_serr, 0);

    run_patch(117, 195, 0, 20'd0, 0, 500);
    check("abort_handshakes", res_hs, 500);
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    reset = 1'b0;
    run_patch(117, 195, 0, 20'd0, 0, -1);
    check("restart_first_valid_cycle", res_fvcyc, 2);
    check("restart_first_tl", res_ftl, 103603);
    check("restart_handshakes", res_hs, NWIN);
    check("restart_window_seq", res_serr, 0);

    run_patch(117, 195, 0, 20'd0, 2, -1);
    check("stray_start_handshakes", res_hs, NWIN);
    check("stray_start_patch_done_n", res_pdn, 1);
    check("stray_start_window_seq", res_serr, 0);
    check("stray_start_busy_fall", res_endcyc, 1091);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
